posit_class_arbiter: RTL and testbench

Shares one `posit_classifier` (one operand) among `NumReq` requesters. Each requester issues posit operands over a valid/ready handshake. Grants are round-robin. The classification result is registered into a one-entry output stage with its own valid/ready handshake. The block sits in the posit FPU, between the issuing units and the classification consumers (branch/compare logic and the class-query path).

---
 rtl/posit_pkg.sv | 38 +++
 rtl/posit_classifier.sv | 28 ++
 rtl/posit_rr_arbiter.sv | 52 +++++
 rtl/posit_class_arbiter.sv | 80 ++++++++
 tb/tb_posit_class_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/posit_pkg.sv
// Shared posit FPU types: operand formats, classification flags and the class-arbiter result record.
// Pure declarations; no timing or backpressure of its own.
package posit_pkg;

  typedef enum logic [1:0] {
    POSIT32 = 2'd0,
    POSIT16 = 2'd1,
    POSIT8  = 2'd2,
    POSIT64 = 2'd3
  } posit_format_e;

  function automatic int posit_width(posit_format_e fmt);
    case (fmt)
      POSIT16: return 16;
      POSIT8:  return 8;
      POSIT64: return 64;
      default: return 32;
    endcase
  endfunction

  typedef struct packed {
    logic is_zero;
    logic is_NaR;
    logic is_pos;
    logic is_neg;
  } posit_info_t;

  // Fields sized for the widest supported arbiter; narrower instances zero-extend id/tag.
  localparam int ClassIdWidth  = 8;
  localparam int ClassTagWidth = 16;

  typedef struct packed {
    posit_info_t              info;
    logic [ClassIdWidth-1:0]  id;
    logic [ClassTagWidth-1:0] tag;
  } posit_class_res_t;

endpackage

// File: rtl/posit_classifier.sv
// Combinational posit classifier: zero / NaR / positive / negative flags per operand.
// Zero latency, no state, no backpressure.
module posit_classifier
  import posit_pkg::*;
#(
  parameter posit_format_e pFormat     = posit_format_e'(0),
  parameter int            NumOperands = 1,
  localparam int           WIDTH       = posit_width(pFormat)
) (
  input  logic        [NumOperands-1:0][WIDTH-1:0] operands_i,
  output posit_info_t [NumOperands-1:0]            info_o
);

  always_comb begin
    info_o = '0;
    for (int i = 0; i < NumOperands; i++) begin
      logic msb;
      logic rest_zero;
      msb       = operands_i[i][WIDTH-1];
      rest_zero = ~|operands_i[i][WIDTH-2:0];
      info_o[i].is_zero = !msb && rest_zero;
      info_o[i].is_NaR  = msb && rest_zero;
      info_o[i].is_pos  = !msb && !rest_zero;
      info_o[i].is_neg  = msb && !rest_zero;
    end
  end

endmodule

// File: rtl/posit_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid index at or after ptr, wrapping.
// Grant is combinational; ptr advances past the winner on the edge a grant is issued, holds when en_i is low.
module posit_rr_arbiter #(
  parameter int  NumReq  = 4,
  localparam int IdWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumReq-1:0]  req_i,
  input  logic               en_i,
  output logic [NumReq-1:0]  gnt_o,
  output logic [IdWidth-1:0] gnt_id_o,
  output logic               gnt_vld_o
);

  logic [IdWidth-1:0] ptr_q;
  logic               hi_found;
  logic               lo_found;
  logic [IdWidth-1:0] hi_id;
  logic [IdWidth-1:0] lo_id;

  // Two scans: first valid at/after ptr wins, otherwise the first valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (req_i[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = IdWidth'(i);
      end
      if (req_i[i] && !hi_found && (i >= int'(ptr_q))) begin
        hi_found = 1'b1;
        hi_id    = IdWidth'(i);
      end
    end
    gnt_vld_o = en_i && lo_found;
    gnt_id_o  = hi_found ? hi_id : lo_id;
    gnt_o     = '0;
    if (gnt_vld_o) gnt_o[gnt_id_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (gnt_vld_o) begin
      ptr_q <= (gnt_id_o == IdWidth'(NumReq - 1)) ? '0 : gnt_id_o + IdWidth'(1);
    end
  end

endmodule

// File: rtl/posit_class_arbiter.sv
// Shares one posit classifier among NumReq requesters with round-robin grants into a one-entry result stage.
// Latency 1 cycle; grants are withheld while the result stage is held by res_ready_i low or on flush.
module posit_class_arbiter
  import posit_pkg::*;
#(
  parameter posit_format_e pFormat  = posit_format_e'(0),
  parameter int            NumReq   = 4,
  parameter int            TagWidth = 4,
  localparam int           WIDTH    = posit_width(pFormat),
  localparam int           IdWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic        [NumReq-1:0]           req_valid_i,
  output logic        [NumReq-1:0]           req_ready_o,
  input  logic        [NumReq-1:0][WIDTH-1:0]    req_operand_i,
  input  logic        [NumReq-1:0][TagWidth-1:0] req_tag_i,
  input  logic                               flush_i,
  output logic                               res_valid_o,
  input  logic                               res_ready_i,
  output posit_info_t                        res_info_o,
  output logic        [IdWidth-1:0]          res_id_o,
  output logic        [TagWidth-1:0]         res_tag_o
);

  logic               accept;
  logic [NumReq-1:0]  gnt;
  logic [IdWidth-1:0] gnt_id;
  logic               gnt_vld;
  logic [WIDTH-1:0]   gnt_operand;
  posit_info_t        gnt_info;
  posit_class_res_t   res_q;

  // Result stage can take a new entry when empty or draining this cycle; flush and reset block it.
  assign accept = !rst_i && !flush_i && (!res_valid_o || res_ready_i);

  posit_rr_arbiter #(
    .NumReq(NumReq)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_valid_i),
    .en_i     (accept),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .gnt_vld_o(gnt_vld)
  );

  assign req_ready_o = gnt;
  assign gnt_operand = req_operand_i[gnt_id];

  posit_classifier #(
    .pFormat    (pFormat),
    .NumOperands(1)
  ) u_cls (
    .operands_i(gnt_operand),
    .info_o    (gnt_info)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_o <= 1'b0;
      res_q       <= '0;
    end else if (flush_i) begin
      res_valid_o <= 1'b0;
    end else if (gnt_vld) begin
      res_valid_o <= 1'b1;
      res_q       <= '{info: gnt_info,
                       id:   ClassIdWidth'(gnt_id),
                       tag:  ClassTagWidth'(req_tag_i[gnt_id])};
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

  assign res_info_o = res_q.info;
  assign res_id_o   = IdWidth'(res_q.id);
  assign res_tag_o  = TagWidth'(res_q.tag);

endmodule

// File: tb/tb_posit_class_arbiter.sv
// Directed bench for posit_class_arbiter: scoreboard of issued requests versus presented results,
// plus direct grant/stability checks for round robin, backpressure, flush and reset.
module tb_posit_class_arbiter;
  import posit_pkg::*;

  localparam logic [3:0] C_ZERO = 4'b1000;
  localparam logic [3:0] C_NAR  = 4'b0100;
  localparam logic [3:0] C_POS  = 4'b0010;
  localparam logic [3:0] C_NEG  = 4'b0001;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [3:0]            req_valid_i;
  logic [3:0]            req_ready_o;
  logic [3:0][31:0]      req_operand_i;
  logic [3:0][3:0]       req_tag_i;
  logic                  flush_i;
  logic                  res_valid_o;
  logic                  res_ready_i;
  posit_info_t           res_info_o;
  logic [1:0]            res_id_o;
  logic [3:0]            res_tag_o;
  logic [3:0]            res_info_bits;

  assign res_info_bits = res_info_o;

  posit_class_arbiter #(
    .pFormat (POSIT32),
    .NumReq  (4),
    .TagWidth(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_operand_i(req_operand_i),
    .req_tag_i    (req_tag_i),
    .flush_i      (flush_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_info_o   (res_info_o),
    .res_id_o     (res_id_o),
    .res_tag_o    (res_tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] info;
    logic [1:0] id;
    logic [3:0] tag;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] exp_info [4];
  int         checks = 0;
  int         errors = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Issue side: every accepted request pushes its hand-computed expected result.
  always @(negedge clk_i) begin
    if (rst_i === 1'b0) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid_i[i] && req_ready_o[i] === 1'b1) begin
          exp_t e;
          e.info = exp_info[i];
          e.id   = 2'(i);
          e.tag  = req_tag_i[i];
          sbq.push_back(e);
        end
      end
    end
  end

  // Monitor: pop and compare whenever a result is consumed; flush/reset discard pending entries.
  always @(negedge clk_i) begin
    if (res_valid_o === 1'b1) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_result", 32'(res_id_o), 32'hFFFF);
      end else if (flush_i === 1'b1) begin
        void'(sbq.pop_front());
      end else if (res_ready_i === 1'b1) begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_info", 32'(res_info_bits), 32'(e.info));
        check("sb_id",   32'(res_id_o),      32'(e.id));
        check("sb_tag",  32'(res_tag_o),     32'(e.tag));
      end
    end
    if (rst_i === 1'b1) sbq.delete();
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_gnt(string nm, logic [3:0] e);
    #1;
    check(nm, 32'(req_ready_o), 32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int         seq_all [6];
    int         seq_drop[4];
    logic [31:0] cls_op [4];
    logic [3:0]  cls_exp[4];
    seq_all  = '{0, 1, 2, 3, 0, 1};
    seq_drop = '{3, 0, 1, 3};
    cls_op   = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h6000_0001};
    cls_exp  = '{C_ZERO, C_NAR, C_NEG, C_POS};

    req_operand_i[0] = 32'h0000_0000; exp_info[0] = C_ZERO;
    req_operand_i[1] = 32'h8000_0000; exp_info[1] = C_NAR;
    req_operand_i[2] = 32'h4000_0000; exp_info[2] = C_POS;
    req_operand_i[3] = 32'hC000_0000; exp_info[3] = C_NEG;
    for (int i = 0; i < 4; i++) req_tag_i[i] = 4'(8 + i);
    rst_i       = 1'b1;
    req_valid_i = 4'hF;
    res_ready_i = 1'b1;
    flush_i     = 1'b0;

    // Reset held for two cycles with everyone requesting.
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_gnt("rst_ready", 4'b0000);
      check("rst_res_valid", 32'(res_valid_o), 32'd0);
    end
    rst_i = 1'b0;

    for (int k = 0; k < 6; k++) begin
      chk_gnt($sformatf("rr_all_%0d", k), 4'(1 << seq_all[k]));
      tick();
    end
    req_valid_i = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      chk_gnt($sformatf("rr_drop2_%0d", k), 4'(1 << seq_drop[k]));
      tick();
    end

    // Requester 1 alone through the four posit classes.
    req_valid_i  = 4'b0010;
    req_tag_i[1] = 4'd1;
    for (int k = 0; k < 4; k++) begin
      req_operand_i[1] = cls_op[k];
      exp_info[1]      = cls_exp[k];
      chk_gnt($sformatf("cls_gnt_%0d", k), 4'b0010);
      tick();
      check($sformatf("cls_valid_%0d", k), 32'(res_valid_o),   32'd1);
      check($sformatf("cls_info_%0d", k),  32'(res_info_bits), 32'(cls_exp[k]));
      check($sformatf("cls_id_%0d", k),    32'(res_id_o),      32'd1);
      check($sformatf("cls_tag_%0d", k),   32'(res_tag_o),     32'd1);
    end

    // Stall with a positive result from requester 1 pending; ptr sits at 2.
    req_valid_i = 4'hF;
    res_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_gnt($sformatf("bp_gnt_%0d", k), 4'b0000);
      check($sformatf("bp_valid_%0d", k), 32'(res_valid_o),   32'd1);
      check($sformatf("bp_info_%0d", k),  32'(res_info_bits), 32'(C_POS));
      check($sformatf("bp_id_%0d", k),    32'(res_id_o),      32'd1);
      check($sformatf("bp_tag_%0d", k),   32'(res_tag_o),     32'd1);
      tick();
    end
    res_ready_i = 1'b1;
    chk_gnt("bp_resume_gnt", 4'b0100);
    tick();
    check("bp_resume_id", 32'(res_id_o), 32'd2);

    // Flush the requester-2 result while the consumer is ready.
    flush_i = 1'b1;
    chk_gnt("fl_gnt", 4'b0000);
    tick();
    flush_i = 1'b0;
    check("fl_valid_after", 32'(res_valid_o), 32'd0);
    chk_gnt("fl_next_gnt", 4'b1000);
    tick();

    // Reset with a result pending and requesters 2/3 valid.
    req_valid_i = 4'b1100;
    rst_i       = 1'b1;
    chk_gnt("rstm_gnt", 4'b0000);
    tick();
    check("rstm_valid_after", 32'(res_valid_o), 32'd0);
    rst_i = 1'b0;
    chk_gnt("rstm_release_gnt", 4'b0100);
    tick();
    check("rstm_res_id", 32'(res_id_o), 32'd2);
    req_valid_i = 4'b0000;
    tick();
    tick();
    check("drain_valid", 32'(res_valid_o), 32'd0);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
